// File: rtl/alu_issue.sv
// alu_issue: issue/writeback stage in front of the cpu2 8-bit ALU.
// Holds a 4-entry register file that is filled through a load port. Each
// instruction walks IDLE -> READ -> EXEC -> WRITE. The stage drives ALU
// operands from registers, captures the ALU result in EXEC and commits it
// to the register file in WRITE, with a one-cycle writeback strobe.
module alu_issue #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [1:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [1:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [7:0]        instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state_reg;
  logic [1:0]        op_reg;
  logic [1:0]        rd_reg;
  logic [1:0]        rs_a_reg;
  logic [1:0]        rs_b_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [1:0]        alu_op_reg;
  logic              wb_valid_reg;
  logic [1:0]        wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [7:0]        instr_count_reg;

  // Read view of the register file entries.
  logic [DATA_W-1:0] rf_q [4];

  logic ld_fire;
  logic instr_fire;

  // Both ready outputs are gated by rst_n so they drop the moment reset
  // asserts. A pending load wins over an instruction presented in the
  // same cycle; the instruction simply waits one more cycle.
  assign ld_ready    = rst_n && (state_reg == IDLE);
  assign instr_ready = rst_n && (state_reg == IDLE) && !ld_valid;
  assign ld_fire     = ld_valid && ld_ready;
  assign instr_fire  = instr_valid && instr_ready;

  // One flop bank per register file entry. Loads only happen in IDLE and
  // writebacks only in WRITE, so the two write sources never collide.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rf
    logic [DATA_W-1:0] entry_reg;
    logic              ld_hit;
    logic              wb_hit;

    assign ld_hit = ld_fire && (ld_addr == 2'(gi));
    assign wb_hit = (state_reg == WRITE) && (wb_addr_reg == 2'(gi));

    // Entry update from the load port or from the writeback latch.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (ld_hit) begin
        entry_reg <= ld_data;
      end else if (wb_hit) begin
        entry_reg <= wb_data_reg;
      end
    end

    assign rf_q[gi] = entry_reg;
  end

  // Issue FSM: latches the instruction, reads operands, captures the ALU
  // result and commits it. All ALU-facing and writeback outputs are
  // registered here; operands hold their values outside READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      op_reg          <= '0;
      rd_reg          <= '0;
      rs_a_reg        <= '0;
      rs_b_reg        <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_op_reg      <= '0;
      wb_valid_reg    <= 1'b0;
      wb_addr_reg     <= '0;
      wb_data_reg     <= '0;
      instr_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (instr_fire) begin
            op_reg    <= instr[7:6];
            rd_reg    <= instr[5:4];
            rs_a_reg  <= instr[3:2];
            rs_b_reg  <= instr[1:0];
            state_reg <= READ;
          end
        end
        READ: begin
          // rs_a == rs_b is fine: both operands read the same entry.
          alu_a_reg  <= rf_q[rs_a_reg];
          alu_b_reg  <= rf_q[rs_b_reg];
          alu_op_reg <= op_reg;
          state_reg  <= EXEC;
        end
        EXEC: begin
          // The ALU has had a full cycle since the operands settled.
          wb_data_reg  <= alu_result;
          wb_addr_reg  <= rd_reg;
          wb_valid_reg <= 1'b1;
          state_reg    <= WRITE;
        end
        WRITE: begin
          // The register file entry picks up wb_data_reg on this same edge.
          wb_valid_reg    <= 1'b0;
          instr_count_reg <= instr_count_reg + 8'd1;
          state_reg       <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_op      = alu_op_reg;
  assign wb_valid    = wb_valid_reg;
  assign wb_addr     = wb_addr_reg;
  assign wb_data     = wb_data_reg;
  assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a reference ALU, a
// register file model and a writeback scoreboard queue.
`timescale 1ns/1ps
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ld_valid = 1'b0;
  logic [1:0] ld_addr = 2'd0;
  logic [7:0] ld_data = 8'd0;
  logic       ld_ready;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'd0;
  logic       instr_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic [7:0] instr_count;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } wb_t;

  wb_t        sb[$];
  logic [7:0] m_regs [4];
  logic [7:0] m_count;

  int cyc = 0;
  int wb_pulses = 0;
  int acc_cyc[$];

  always #5 clk = ~clk;

  alu_issue #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .instr_count(instr_count)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Stand-in for the combinational cpu2 ALU.
  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  // Edge monitor: cycle counter, writeback-high cycles, accept cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wb_valid) wb_pulses <= wb_pulses + 1;
    if (instr_valid && instr_ready) acc_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_count = 8'h00;
    sb.delete();
  endtask

  // Assert reset with both requests active, check reset values, release.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 8'hAA;
    instr_valid = 1'b1; instr = 8'h01;
    #1;
    check("rst_async_wb_valid", wb_valid, 0);
    check("rst_async_count", instr_count, 0);
    repeat (n) tick();
    check("rst_ld_ready", ld_ready, 0);
    check("rst_instr_ready", instr_ready, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_count", instr_count, 0);
    rst_n = 1'b1;
    ld_valid = 1'b0;
    instr_valid = 1'b0;
    #1;
    check("post_rst_ld_ready", ld_ready, 1);
    model_clear();
  endtask

  task automatic do_load(input logic [1:0] a, input logic [7:0] d);
    bit ok;
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      #0;
      if (ld_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) check("ld_ready_timeout", 0, 1);
    tick();
    ld_valid = 1'b0;
    if (ok) m_regs[a] = d;
  endtask

  // Present one instruction, follow it through READ/EXEC/WRITE and check
  // every stage. hold keeps instr_valid high afterwards; wiggle toggles
  // instr_valid with junk payloads while the stage is busy.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input bit hold, input bit wiggle,
                       output logic [7:0] wb_obs);
    bit  ok;
    wb_t e;
    wb_t got;
    instr = {op, rd, ra, rb};
    instr_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      #0;
      if (instr_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      check("instr_ready_timeout", 0, 1);
      instr_valid = 1'b0;
      wb_obs = 'x;
      return;
    end
    e.addr = rd;
    e.data = alu_f(m_regs[ra], m_regs[rb], op);
    sb.push_back(e);
    tick();  // E0: accepted
    if (!hold) instr_valid = 1'b0;
    if (wiggle) begin instr_valid = 1'b1; instr = 8'($urandom); end
    check("busy_instr_ready", instr_ready, 0);
    check("busy_ld_ready", ld_ready, 0);
    tick();  // E1: operands registered
    check("alu_a", alu_a, m_regs[ra]);
    check("alu_b", alu_b, m_regs[rb]);
    check("alu_op", alu_op, op);
    check("wb_valid_early", wb_valid, 0);
    if (wiggle) begin instr_valid = 1'b0; instr = 8'($urandom); end
    tick();  // E2: writeback presented
    check("wb_valid", wb_valid, 1);
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("wb_addr", wb_addr, got.addr);
      check("wb_data", wb_data, got.data);
    end
    wb_obs = wb_data;
    check("count_pre_commit", instr_count, m_count);
    if (wiggle) begin instr_valid = 1'b1; instr = 8'($urandom); end
    tick();  // E3: committed
    check("wb_valid_drop", wb_valid, 0);
    m_regs[rd] = e.data;
    m_count = m_count + 8'd1;
    check("instr_count", instr_count, m_count);
    check("ready_after_wb", instr_ready, 1);
    if (wiggle) instr_valid = hold;
  endtask

  logic [7:0] obs;
  int p0;
  int a0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    // Reset with both requests active; r1 must not pick up 0xAA.
    do_reset(3);
    issue(2'd3, 2'd2, 2'd1, 2'd1, 0, 0, obs);
    check("rst_no_load_r1", obs, 8'h00);
    do_reset(1);

    // Load + add, then OR of the updated r0 with itself.
    p0 = wb_pulses;
    do_load(2'd0, 8'h05);
    do_load(2'd1, 8'h06);
    check("no_wb_for_loads", wb_pulses - p0, 0);
    issue(2'd0, 2'd0, 2'd0, 2'd1, 0, 0, obs);
    check("add_result", obs, 8'h0B);
    check("add_count", instr_count, 1);
    issue(2'd3, 2'd2, 2'd0, 2'd0, 0, 0, obs);
    check("or_result", obs, 8'h0B);

    // Subtract wrap.
    do_load(2'd2, 8'h00);
    do_load(2'd3, 8'h01);
    issue(2'd1, 2'd1, 2'd2, 2'd3, 0, 0, obs);
    check("sub_wrap", obs, 8'hFF);

    // Load and instruction together: load wins, instruction next cycle.
    ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 8'h10;
    instr_valid = 1'b1; instr = {2'd0, 2'd0, 2'd3, 2'd3};
    #1;
    check("prio_instr_ready", instr_ready, 0);
    check("prio_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    m_regs[3] = 8'h10;
    p0 = cyc;
    a0 = acc_cyc.size();
    issue(2'd0, 2'd0, 2'd3, 2'd3, 0, 0, obs);
    check("prio_sum", obs, 8'h20);
    check("prio_accepts", acc_cyc.size() - a0, 1);
    if (acc_cyc.size() > a0) check("prio_next_cycle", acc_cyc[a0], p0);

    // Back-to-back with instr_valid held high; junk toggling while busy.
    do_reset(1);
    do_load(2'd0, 8'h21);
    do_load(2'd1, 8'h13);
    a0 = acc_cyc.size();
    p0 = wb_pulses;
    issue(2'd0, 2'd2, 2'd0, 2'd1, 1, 0, obs);
    issue(2'd1, 2'd3, 2'd2, 2'd1, 1, 1, obs);
    issue(2'd2, 2'd0, 2'd3, 2'd0, 1, 1, obs);
    instr_valid = 1'b0;
    check("b2b_accepts", acc_cyc.size() - a0, 3);
    if (acc_cyc.size() >= a0 + 3) begin
      check("b2b_gap1", acc_cyc[a0+1] - acc_cyc[a0], 4);
      check("b2b_gap2", acc_cyc[a0+2] - acc_cyc[a0+1], 4);
    end
    check("b2b_pulses", wb_pulses - p0, 3);
    check("b2b_count", instr_count, 3);

    // Reset while in EXEC: nothing written back, everything cleared.
    do_load(2'd0, 8'h33);
    do_load(2'd1, 8'h44);
    do_load(2'd2, 8'h55);
    do_load(2'd3, 8'h66);
    instr = {2'd0, 2'd2, 2'd0, 2'd1};
    instr_valid = 1'b1;
    #1;
    check("midrst_ready", instr_ready, 1);
    tick();  // E0
    instr_valid = 1'b0;
    tick();  // E1, now in EXEC
    p0 = wb_pulses;
    do_reset(2);
    repeat (3) tick();
    check("midrst_no_wb", wb_pulses - p0, 0);
    check("midrst_count", instr_count, 0);
    issue(2'd3, 2'd0, 2'd0, 2'd1, 0, 0, obs);
    check("midrst_r0r1_zero", obs, 8'h00);
    issue(2'd3, 2'd1, 2'd2, 2'd3, 0, 0, obs);
    check("midrst_r2r3_zero", obs, 8'h00);

    // 254 more random instructions: 256 since reset, counter wraps to 0.
    for (int k = 0; k < 254; k++) begin
      if (k % 16 == 5) do_load(2'($urandom_range(0, 3)), 8'($urandom));
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, 0, obs);
    end
    check("count_wrap", instr_count, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue/writeback stage that sits directly upstream of the 8-bit `ALU` in cpu2. It holds a 4-entry × 8-bit register file, loaded through a load port. It accepts 8-bit register-to-register instructions over a valid/ready handshake and drives `operandA`, `operandB` and `operation` into the ALU from registers. It captures the ALU `result` and writes it back to the destination register, reporting each completion on a one-cycle writeback strobe.

## Interface
- `DATA_W`, 8, width of register file entries and ALU operands/result; must match the ALU (8).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `ld_valid`  in  1  load request.
- `ld_addr`  in  2  register to load.
- `ld_data`  in  DATA_W  load value.
- `ld_ready`  out  1  load accepted when `ld_valid && ld_ready` at a rising edge.
- `instr_valid`  in  1  instruction request.
- `instr`  in  8  instruction: [7:6] op, [5:4] rd, [3:2] rs_a, [1:0] rs_b.
- `instr_ready`  out  1  instruction accepted when `instr_valid && instr_ready` at a rising edge.
- `alu_a`  out  DATA_W  to ALU `operandA`, registered.
- `alu_b`  out  DATA_W  to ALU `operandB`, registered.
- `alu_op`  out  2  to ALU `operation`, registered.
- `alu_result`  in  DATA_W  from ALU `result`, combinational in the ALU.
- `wb_valid`  out  1  one-cycle pulse: writeback in progress.
- `wb_addr`  out  2  destination register of current writeback.
- `wb_data`  out  DATA_W  value being written back.
- `instr_count`  out  8  completed instructions, wraps 255→0.

## Operation
- The FSM has four states: IDLE → READ → EXEC → WRITE → IDLE. There are no other transitions, and no state is skipped.
- `ld_ready` = `rst_n && state==IDLE`.
- `instr_ready` = `rst_n && state==IDLE && !ld_valid`. A load has priority over an instruction in the same cycle, and the instruction waits.
- Load accept: `regs[ld_addr] <= ld_data` at that edge. State remains IDLE, so back-to-back loads run one per cycle.
- Instruction accept in IDLE:
  - The `instr` fields are latched into internal rd/rs_a/rs_b/op registers.
  - The state moves to READ.
- READ:
  - `alu_a <= regs[rs_a]`, `alu_b <= regs[rs_b]`, `alu_op <= op`.
  - The state moves to EXEC.
- EXEC:
  - `wb_data <= alu_result`, `wb_addr <= rd`, `wb_valid <= 1`.
  - The state moves to WRITE.
- WRITE:
  - `regs[wb_addr] <= wb_data`, `wb_valid <= 0`, `instr_count <= instr_count + 1` (mod 256).
  - The state moves to IDLE.
- rs_a == rs_b is legal, and both operands read the same entry. rd may equal either source; the write occurs after the operand read.
- `alu_a`, `alu_b` and `alu_op` hold their last values outside READ. The ALU output is ignored except in EXEC.
- `ld_valid` and `instr_valid` are ignored outside IDLE. The upstream must hold request and payload until ready.
- The block performs no arithmetic other than the `instr_count` increment. Widths pass through unchanged.

## Timing
- Reset values:
  - Registers and FSM while `rst_n` is low: regs[0..3] = 0, state = IDLE, `alu_a` = `alu_b` = 0, `alu_op` = 0.
  - `wb_valid` = 0, `wb_addr` = 0, `wb_data` = 0, `instr_count` = 0.
  - `ld_ready` and `instr_ready` are 0 while `rst_n` is low.
- Reset mid-operation, in any state:
  - Everything clears immediately and asynchronously. Any in-flight instruction is discarded with no writeback and no count increment.
  - `wb_valid` drops at once if it was high.
- Instruction latency, with the instruction accepted at edge E0:
  - Operands are valid on `alu_*` after E1.
  - `alu_result` is sampled at E2, and `wb_valid`/`wb_addr`/`wb_data` are valid from E2 to E3.
  - The register-file write and count increment occur at E3.
  - `instr_ready` returns high after E3. The next instruction can be accepted at E4 earliest.
- Throughput is one instruction per 4 cycles. The ALU path from `alu_*` registers to `alu_result` has one full clock period.
- A load accepted at edge E is visible to an instruction accepted at any edge ≥ E+1. There is no forwarding, and none is needed.
- `wb_valid` is exactly one cycle wide per instruction and never asserts for loads.

## Test plan
- The bench ALU model computes: op0 = a+b mod 256, op1 = a−b mod 256, op2 = a&b, op3 = a|b.
- Reset: hold `rst_n` low 3 cycles with `ld_valid` = `instr_valid` = 1. Required: all outputs at reset values, both ready outputs 0, no register written. After release, `ld_ready` = 1.
- Load + add: load r0 = 0x05 and r1 = 0x06, then send instr 0x01 (op0, rd=r0, rs_a=r0, rs_b=r1). Required: `alu_a` = 0x05, `alu_b` = 0x06 after E1; `wb_valid` pulse with `wb_addr` = 0, `wb_data` = 0x0B at E2–E3; `instr_count` = 1. A following op3 r2 = r0|r0 gives `wb_data` = 0x0B.
- Wrap and priority:
  - Load r2 = 0x00 and r3 = 0x01, then issue op1 r1 = r2−r3. Required: `wb_data` = 0xFF.
  - Assert `ld_valid` and `instr_valid` together in IDLE. Required: the load is taken, `instr_ready` = 0 that cycle, and the instruction is taken the next cycle.
- Back-to-back: hold `instr_valid` high for 3 instructions. Required: accepts exactly every 4 cycles, 3 `wb_valid` pulses, `instr_count` = 3. `instr_valid` toggled during READ/EXEC/WRITE has no effect.
- Reset mid-operation: drop `rst_n` during EXEC. Required: no `wb_valid`, `instr_count` unchanged at 0, all regs 0. Run 256 instructions and check that `instr_count` wraps to 0.
